// File: rtl/key_press_pkg.sv
// Shared types and default sizing for the key debouncer and its counters.
package key_pkg;

    // Debouncer FSM states. All four encodings are used.
    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        DB_PRESS   = 2'd1,
        HELD       = 2'd2,
        DB_RELEASE = 2'd3
    } key_state_t;

    localparam int DEBOUNCE_DEF = 4;
    localparam int CNT_W_DEF    = 3;
    localparam int COUNT_W_DEF  = 8;

    // The key counts as down while held or while a release is still being debounced.
    function automatic logic is_down(input key_state_t s);
        return (s == HELD) || (s == DB_RELEASE);
    endfunction

endpackage

// File: rtl/key_press_if.sv
// Key event bundle between the synchronizer side and the game datapath.
// 'release' is a reserved word, so the release pulse is called 'rel'.
interface key_press_if #(
    parameter int COUNT_W = 8
);
    logic               raw;
    logic               clr;
    logic               press;
    logic               rel;
    logic               held;
    logic [COUNT_W-1:0] press_count;

    modport master (
        output raw, clr,
        input  press, rel, held, press_count
    );

    modport slave (
        input  raw, clr,
        output press, rel, held, press_count
    );
endinterface

// File: rtl/key_press_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    // Count up on inc, hold at all-ones, clear has priority.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/key_press.sv
// Debounces the synchronized key level into press/release pulses, a held
// level and a saturating press tally.
module key_press
    import key_pkg::*;
#(
    parameter int DEBOUNCE = DEBOUNCE_DEF,
    parameter int CNT_W    = CNT_W_DEF,
    parameter int COUNT_W  = COUNT_W_DEF
) (
    input  logic       clk,
    input  logic       reset,
    key_press_if.slave bus
);

    // Counter value on the edge that completes the debounce window.
    localparam logic [CNT_W-1:0] LAST   = CNT_W'(DEBOUNCE - 1);
    // With a one-sample window the debounce states are skipped entirely.
    localparam bit               SINGLE = (DEBOUNCE == 1);

    key_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             press_nxt, rel_nxt;
    logic             press_q, rel_q, held_q;

    // State, debounce counter and registered outputs.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            press_q <= press_nxt;
            rel_q   <= rel_nxt;
            held_q  <= is_down(state_nxt);
        end
    end

    // Next state and next counter value from the current raw sample.
    always_comb begin
        // NOTE: defaults first so no path through the case leaves a latch.
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (bus.raw) begin
                    if (SINGLE) begin
                        state_nxt = HELD;
                        cnt_nxt   = '0;
                    end else begin
                        state_nxt = DB_PRESS;
                        cnt_nxt   = CNT_W'(1);
                    end
                end
            end
            DB_PRESS: begin
                if (!bus.raw) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == LAST) begin
                    state_nxt = HELD;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            HELD: begin
                if (!bus.raw) begin
                    if (SINGLE) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end else begin
                        state_nxt = DB_RELEASE;
                        cnt_nxt   = CNT_W'(1);
                    end
                end
            end
            DB_RELEASE: begin
                if (bus.raw) begin
                    state_nxt = HELD;
                    cnt_nxt   = '0;
                end else if (cnt == LAST) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Pulses fire only on a completed up/down transition, never on a bounce.
    always_comb begin
        press_nxt = !is_down(state) && (state_nxt == HELD);
        rel_nxt   = is_down(state) && (state_nxt == IDLE);
    end

    assign bus.press = press_q;
    assign bus.rel   = rel_q;
    assign bus.held  = held_q;

    sat_counter #(
        .WIDTH(COUNT_W)
    ) u_press_count (
        .clk   (clk),
        .reset (reset),
        .inc   (press_q),
        .clr   (bus.clr),
        .count (bus.press_count)
    );

endmodule

// File: tb/tb_key_press.sv
// Directed bench for key_press: a vector table on the default configuration,
// plus hand sequences for saturation/clear (COUNT_W=2) and DEBOUNCE=1.
module tb_key_press;

    logic clk = 1'b0;
    logic reset;
    logic raw;
    logic clr;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    key_press_if #(.COUNT_W(8)) if_a ();
    key_press_if #(.COUNT_W(2)) if_b ();
    key_press_if #(.COUNT_W(8)) if_c ();

    assign if_a.raw = raw;
    assign if_a.clr = clr;
    assign if_b.raw = raw;
    assign if_b.clr = clr;
    assign if_c.raw = raw;
    assign if_c.clr = clr;

    key_press #(.DEBOUNCE(4), .CNT_W(3), .COUNT_W(8)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (if_a)
    );

    key_press #(.DEBOUNCE(4), .CNT_W(3), .COUNT_W(2)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (if_b)
    );

    key_press #(.DEBOUNCE(1), .CNT_W(3), .COUNT_W(8)) dut_c (
        .clk   (clk),
        .reset (reset),
        .bus   (if_c)
    );

    typedef struct {
        logic       rst;
        logic       raw;
        logic       clr;
        logic       press;
        logic       rel;
        logic       held;
        logic [7:0] cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    // Apply inputs, take one edge, settle just after it.
    task automatic step(input logic r, input logic w, input logic c);
        reset = r;
        raw   = w;
        clr   = c;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input int n, input logic r, input logic w, input logic c,
                       input logic p, input logic rl, input logic h, input int cnt);
        vec_t v;
        v.rst = r; v.raw = w; v.clr = c;
        v.press = p; v.rel = rl; v.held = h; v.cnt = 8'(cnt);
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    // One full press/release on the default and COUNT_W=2 instances.
    task automatic press_release(input int exp_a, input int exp_b);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0);
        check("sat press_b", {31'd0, if_b.press}, 32'd1);
        step(1'b0, 1'b0, 1'b0);
        check("sat count_b", {30'd0, if_b.press_count}, 32'(exp_b));
        check("sat count_a", {24'd0, if_a.press_count}, 32'(exp_a));
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
        check("sat rel_b", {31'd0, if_b.rel}, 32'd1);
    endtask

    initial begin
        reset = 1'b1;
        raw   = 1'b0;
        clr   = 1'b0;

        // Clean press: reset, 3 lows, 10 highs.
        add(1, 1, 0, 0, 0, 0, 0, 0);
        add(3, 0, 0, 0, 0, 0, 0, 0);
        add(3, 0, 1, 0, 0, 0, 0, 0);
        add(1, 0, 1, 0, 1, 0, 1, 0);
        add(6, 0, 1, 0, 0, 0, 1, 1);
        // Release bounce from HELD: 0,0,1,0,0,0,0.
        add(2, 0, 0, 0, 0, 0, 1, 1);
        add(1, 0, 1, 0, 0, 0, 1, 1);
        add(3, 0, 0, 0, 0, 0, 1, 1);
        add(1, 0, 0, 0, 0, 1, 0, 1);
        add(1, 0, 0, 0, 0, 0, 0, 1);
        // Bounce rejection after a fresh reset: 1,1,0,1,1,1,0.
        add(1, 1, 0, 0, 0, 0, 0, 0);
        add(2, 0, 1, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0, 0);
        add(3, 0, 1, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0, 0);
        // Reset mid-debounce restarts the window.
        add(2, 0, 1, 0, 0, 0, 0, 0);
        add(1, 1, 1, 0, 0, 0, 0, 0);
        add(3, 0, 1, 0, 0, 0, 0, 0);
        add(1, 0, 1, 0, 1, 0, 1, 0);
        add(1, 0, 1, 0, 0, 0, 1, 1);
        // clr outside a press cycle clears the tally only.
        add(1, 0, 1, 1, 0, 0, 1, 0);
        add(1, 0, 0, 0, 0, 0, 1, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].raw, vecs[i].clr);
            check($sformatf("v%0d press", i), {31'd0, if_a.press}, {31'd0, vecs[i].press});
            check($sformatf("v%0d rel", i),   {31'd0, if_a.rel},   {31'd0, vecs[i].rel});
            check($sformatf("v%0d held", i),  {31'd0, if_a.held},  {31'd0, vecs[i].held});
            check($sformatf("v%0d count", i), {24'd0, if_a.press_count}, {24'd0, vecs[i].cnt});
        end

        // Saturation at COUNT_W=2: 1,2,3,3,3.
        step(1'b1, 1'b0, 1'b0);
        check("sat reset count_b", {30'd0, if_b.press_count}, 32'd0);
        for (int k = 1; k <= 5; k++) press_release(k, (k > 3) ? 3 : k);

        // clr during the press cycle wins over the increment.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0);
        check("clr press_b seen", {31'd0, if_b.press}, 32'd1);
        check("clr count_b before", {30'd0, if_b.press_count}, 32'd3);
        step(1'b0, 1'b1, 1'b1);
        check("clr count_b", {30'd0, if_b.press_count}, 32'd0);
        check("clr count_a", {24'd0, if_a.press_count}, 32'd0);
        step(1'b0, 1'b1, 1'b0);
        check("clr count_b hold", {30'd0, if_b.press_count}, 32'd0);
        check("clr press_b low", {31'd0, if_b.press}, 32'd0);

        // DEBOUNCE=1: raw 0,1,1,0,0.
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check("d1 idle held", {31'd0, if_c.held}, 32'd0);
        check("d1 idle press", {31'd0, if_c.press}, 32'd0);
        step(1'b0, 1'b1, 1'b0);
        check("d1 press", {31'd0, if_c.press}, 32'd1);
        check("d1 held up", {31'd0, if_c.held}, 32'd1);
        check("d1 rel quiet", {31'd0, if_c.rel}, 32'd0);
        step(1'b0, 1'b1, 1'b0);
        check("d1 press once", {31'd0, if_c.press}, 32'd0);
        check("d1 held stays", {31'd0, if_c.held}, 32'd1);
        check("d1 count", {24'd0, if_c.press_count}, 32'd1);
        step(1'b0, 1'b0, 1'b0);
        check("d1 rel", {31'd0, if_c.rel}, 32'd1);
        check("d1 held down", {31'd0, if_c.held}, 32'd0);
        check("d1 press quiet", {31'd0, if_c.press}, 32'd0);
        step(1'b0, 1'b0, 1'b0);
        check("d1 rel once", {31'd0, if_c.rel}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
